alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that performs unsigned WIDTH×WIDTH multiply (shift-add) and WIDTH÷WIDTH divide (restoring) by driving the shared add/sub ALU one step at a time. It sits between the instruction decoder and the ALU input mux. While busy it owns the ALU operand, `i_sub` and flag-latch controls, and it reads back the ALU sum and the latched carry flag. Start/busy/done handshake to the control unit.

---
 rtl/alu_muldiv_seq_if.sv | 33 +++
 rtl/alu_muldiv_seq.sv | 138 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_seq_if.sv
// Control-unit and ALU-side signals of the multiply/divide sequencer.
// master: decoder/control plus the shared ALU; slave: the sequencer itself.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic             i_op;
  logic [WIDTH-1:0] i_x;
  logic [WIDTH-1:0] i_y;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result_lo;
  logic [WIDTH-1:0] o_result_hi;
  logic             o_div_zero;
  logic [WIDTH-1:0] o_alu_a;
  logic [WIDTH-1:0] o_alu_b;
  logic             o_alu_sub;
  logic             o_alu_latch;
  logic [WIDTH-1:0] i_alu_data;
  logic             i_alu_carry;

  modport master (
    output i_start, i_op, i_x, i_y, i_alu_data, i_alu_carry,
    input  o_busy, o_done, o_result_lo, o_result_hi, o_div_zero,
           o_alu_a, o_alu_b, o_alu_sub, o_alu_latch
  );

  modport slave (
    input  i_start, i_op, i_x, i_y, i_alu_data, i_alu_carry,
    output o_busy, o_done, o_result_lo, o_result_hi, o_div_zero,
           o_alu_a, o_alu_b, o_alu_sub, o_alu_latch
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned shift-add multiply / restoring divide, one ALU step per OP+SHIFT pair (2*WIDTH enabled edges).
// Start is only sampled in IDLE; mclk_en=0 freezes all state and outputs.
module alu_muldiv_seq #(
  parameter int WIDTH = 8
) (
  input logic              mclk,
  input logic              rst,
  input logic              mclk_en,
  alu_muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic             op_q, op_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_sub, alu_latch;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      tmp_q   <= '0;
      op_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (mclk_en) begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      tmp_q   <= tmp_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    tmp_d     = tmp_q;
    op_d      = op_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_sub   = 1'b0;
    alu_latch = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          m_d     = bus.i_y;
          lo_d    = bus.i_x;
          hi_d    = '0;
          op_d    = bus.i_op;
          cnt_d   = CW'(WIDTH);
          dz_d    = 1'b0;
          state_d = S_OP;
          if (bus.i_op && (bus.i_y == '0)) begin
            lo_d    = '1;
            hi_d    = bus.i_x;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_OP: begin
        alu_latch = 1'b1;
        tmp_d     = bus.i_alu_data;
        state_d   = S_SHIFT;
        if (op_q) begin
          // Trial subtract of the shifted partial remainder; its lost MSB is kept in ovf.
          alu_a   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
          alu_b   = m_q;
          alu_sub = 1'b1;
          ovf_d   = hi_q[WIDTH-1];
        end else begin
          alu_a = hi_q;
          alu_b = lo_q[0] ? m_q : '0;
        end
      end

      S_SHIFT: begin
        if (op_q) begin
          if (ovf_q || !bus.i_alu_carry) begin
            hi_d = tmp_q;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          {hi_d, lo_d} = {bus.i_alu_carry, tmp_q, lo_q[WIDTH-1:1]};
        end
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? S_DONE : S_OP;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_busy      = (state_q == S_OP) || (state_q == S_SHIFT);
  assign bus.o_done      = (state_q == S_DONE);
  assign bus.o_result_lo = lo_q;
  assign bus.o_result_hi = hi_q;
  assign bus.o_div_zero  = dz_q;
  assign bus.o_alu_a     = alu_a;
  assign bus.o_alu_b     = alu_b;
  assign bus.o_alu_sub   = alu_sub;
  assign bus.o_alu_latch = alu_latch;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: models the shared add/sub ALU with a latched carry,
// runs a vector table through a scoreboard, then stall, ignored-start and reset sequences.
module tb_alu_muldiv_seq;
  localparam int W = 8;

  logic mclk    = 1'b0;
  logic rst     = 1'b1;
  logic mclk_en = 1'b0;

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .mclk    (mclk),
    .rst     (rst),
    .mclk_en (mclk_en),
    .bus     (bus)
  );

  always #5 mclk = ~mclk;

  // ALU model: combinational sum/difference, carry (or borrow) latched on request
  logic [W:0] alu_wide;
  logic       alu_carry_q;

  always_comb begin
    alu_wide = '0;
    if (bus.o_alu_sub) alu_wide = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
    else               alu_wide = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst)                              alu_carry_q <= 1'b0;
    else if (bus.o_alu_latch && mclk_en)  alu_carry_q <= alu_wide[W];
  end

  assign bus.i_alu_data  = alu_wide[W-1:0];
  assign bus.i_alu_carry = alu_carry_q;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         op;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Latency counts edges after the accepting edge until o_done is seen.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edz,
                        input int elat, input bit toggle, input int pulse_at, input int ebusy);
    exp_t e;
    int   edges;
    int   busyc;
    @(negedge mclk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_x     = x;
    bus.i_y     = y;
    mclk_en     = 1'b1;
    e.lo = elo;
    e.hi = ehi;
    e.dz = edz;
    sb.push_back(e);
    @(negedge mclk);
    bus.i_start = 1'b0;
    edges = 0;
    busyc = 0;
    while (!bus.o_done && edges < 200) begin
      if (bus.o_busy) busyc++;
      if (edges == pulse_at) begin
        bus.i_start = 1'b1;
        bus.i_op    = ~op;
        bus.i_x     = 8'hFF;
        bus.i_y     = 8'h03;
      end else begin
        bus.i_start = 1'b0;
      end
      if (toggle) mclk_en = ~mclk_en;
      @(negedge mclk);
      edges++;
    end
    bus.i_start = 1'b0;
    chk("latency", edges, elat);
    chk("busy_cycles", busyc, ebusy);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("result_lo", bus.o_result_lo, e.lo);
      chk("result_hi", bus.o_result_hi, e.hi);
      chk("div_zero", bus.o_div_zero, e.dz);
    end
    if (toggle) begin
      mclk_en = 1'b0;
      @(negedge mclk);
      chk("done_held_in_stall", bus.o_done, 1);
    end
    mclk_en = 1'b1;
    @(negedge mclk);
    chk("done_one_cycle", bus.o_done, 0);
    chk("idle_after_done", bus.o_busy, 0);
  endtask

  vec_t vecs[8];

  initial begin
    bus.i_start = 1'b0;
    bus.i_op    = 1'b0;
    bus.i_x     = '0;
    bus.i_y     = '0;

    vecs[0] = '{x: 8'd13,  y: 8'd11,  op: 1'b0, lo: 8'h8F, hi: 8'h00, dz: 1'b0, lat: 16};
    vecs[1] = '{x: 8'd255, y: 8'd255, op: 1'b0, lo: 8'h01, hi: 8'hFE, dz: 1'b0, lat: 16};
    vecs[2] = '{x: 8'd200, y: 8'd7,   op: 1'b1, lo: 8'd28, hi: 8'd4,  dz: 1'b0, lat: 16};
    vecs[3] = '{x: 8'd250, y: 8'd200, op: 1'b1, lo: 8'd1,  hi: 8'd50, dz: 1'b0, lat: 16};
    vecs[4] = '{x: 8'd255, y: 8'd255, op: 1'b1, lo: 8'd1,  hi: 8'd0,  dz: 1'b0, lat: 16};
    vecs[5] = '{x: 8'd5,   y: 8'd9,   op: 1'b1, lo: 8'd0,  hi: 8'd5,  dz: 1'b0, lat: 16};
    vecs[6] = '{x: 8'd77,  y: 8'd0,   op: 1'b1, lo: 8'hFF, hi: 8'd77, dz: 1'b1, lat: 0};
    vecs[7] = '{x: 8'd6,   y: 8'd7,   op: 1'b0, lo: 8'd42, hi: 8'd0,  dz: 1'b0, lat: 16};

    repeat (2) @(negedge mclk);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_div_zero", bus.o_div_zero, 0);
    chk("rst_lo", bus.o_result_lo, 0);
    chk("rst_hi", bus.o_result_hi, 0);
    chk("rst_alu_latch", bus.o_alu_latch, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].lo, vecs[i].hi, vecs[i].dz,
             vecs[i].lat, 1'b0, -1, (vecs[i].lat == 0) ? 0 : 16);
    end

    // alternating clock enable doubles the edge count
    run_op(8'd13, 8'd11, 1'b0, 8'h8F, 8'h00, 1'b0, 32, 1'b1, -1, 32);

    // start pulse while busy must not disturb the running multiply
    run_op(8'd13, 8'd11, 1'b0, 8'h8F, 8'h00, 1'b0, 16, 1'b0, 5, 16);

    // reset in the middle of an operation
    @(negedge mclk);
    bus.i_start = 1'b1;
    bus.i_op    = 1'b1;
    bus.i_x     = 8'd200;
    bus.i_y     = 8'd7;
    mclk_en     = 1'b1;
    @(negedge mclk);
    bus.i_start = 1'b0;
    repeat (4) @(negedge mclk);
    chk("busy_before_abort", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_done", bus.o_done, 0);
    chk("abort_lo", bus.o_result_lo, 0);
    chk("abort_hi", bus.o_result_hi, 0);
    chk("abort_alu_a", bus.o_alu_a, 0);
    chk("abort_alu_b", bus.o_alu_b, 0);
    chk("abort_alu_sub", bus.o_alu_sub, 0);
    chk("abort_alu_latch", bus.o_alu_latch, 0);
    @(negedge mclk);
    rst = 1'b0;
    run_op(8'd3, 8'd3, 1'b0, 8'd9, 8'd0, 1'b0, 16, 1'b0, -1, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
